// File: rtl/flag_hazard_controller.sv
// Condition-code sequencer: owns the {C,V,N,Z} flag register, evaluates cond codes in
// stage 1 and holds issue while an older in-flight writer of a needed flag group exists.
module flag_hazard_controller #(
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [3:0]       issue_cond,
  input  logic [1:0]       issue_flagwrite,
  output logic             issue_ready,
  input  logic             flush,
  output logic             ex_valid,
  output logic             ex_condex,
  output logic             carry_in,
  input  logic [3:0]       commit_flags,
  output logic             wb_valid,
  output logic [1:0]       wb_flag_we,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] stall_count
);

  // Handshake: issue_valid & issue_ready (& !flush) accepts an instruction into s[1];
  // issue_ready never depends on issue_valid, only on issue_cond and the pipe contents.

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic [1:0] fw;
    logic       condex;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t           r_s [1:LAT];
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_stall_count;

  logic       w_ex_condex;
  logic [1:0] w_pend;
  logic [1:0] w_need;
  logic       w_accept;
  logic       w_wb_condex;
  logic [1:0] w_flag_we;
  logic       w_stall_inc;

  // Flags are packed {C,V,N,Z}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic res;
    res = 1'b0;
    case (c)
      4'd0:    res = f[0];
      4'd1:    res = ~f[0];
      4'd2:    res = f[3];
      4'd3:    res = ~f[3];
      4'd4:    res = f[1];
      4'd5:    res = ~f[1];
      4'd6:    res = f[2];
      4'd7:    res = ~f[2];
      4'd8:    res = f[3] & ~f[0];
      4'd9:    res = ~f[3] | f[0];
      4'd10:   res = (f[1] == f[2]);
      4'd11:   res = (f[1] != f[2]);
      4'd12:   res = ~f[0] & (f[1] == f[2]);
      4'd13:   res = f[0] | (f[1] != f[2]);
      4'd14:   res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Flag groups read by a cond code: [1] = {C,V}, [0] = {N,Z}.
  function automatic logic [1:0] cond_need(input logic [3:0] c);
    logic [1:0] res;
    res = 2'b00;
    case (c)
      4'd0, 4'd1, 4'd4, 4'd5:                   res = 2'b01;
      4'd2, 4'd3, 4'd6, 4'd7:                   res = 2'b10;
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13:  res = 2'b11;
      default:                                  res = 2'b00;
    endcase
    return res;
  endfunction

  always_comb begin
    w_ex_condex = r_s[1].valid & cond_pass(r_s[1].cond, r_flags);
  end

  // s[LAT] is left out: its write lands at this edge, before the next s[1] evaluation.
  always_comb begin
    w_pend = 2'b00;
    for (int i = 1; i < LAT; i++) begin
      if (r_s[i].valid) begin
        w_pend = w_pend | r_s[i].fw;
      end
    end
  end

  always_comb begin
    w_need      = cond_need(issue_cond);
    issue_ready = ~|(w_need & w_pend);
    w_accept    = issue_valid & issue_ready & ~flush;
    w_stall_inc = issue_valid & ~issue_ready & ~flush;
  end

  // With LAT=1 the writer is still in s[1], so its live evaluation gates the write.
  always_comb begin
    w_wb_condex = (LAT == 1) ? w_ex_condex : r_s[LAT].condex;
    w_flag_we   = 2'b00;
    if (r_s[LAT].valid && !flush) begin
      w_flag_we = r_s[LAT].fw & {2{w_wb_condex}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= LAT; i++) begin
        r_s[i] <= '0;
      end
      r_flags       <= 4'b0000;
      r_stall_count <= '0;
    end else begin
      r_s[1].valid  <= w_accept;
      r_s[1].cond   <= issue_cond;
      r_s[1].fw     <= issue_flagwrite;
      r_s[1].condex <= 1'b0;
      for (int i = 2; i <= LAT; i++) begin
        r_s[i].valid  <= r_s[i-1].valid & ~flush;
        r_s[i].cond   <= r_s[i-1].cond;
        r_s[i].fw     <= r_s[i-1].fw;
        r_s[i].condex <= (i == 2) ? w_ex_condex : r_s[i-1].condex;
      end
      if (w_flag_we[1]) begin
        r_flags[3:2] <= commit_flags[3:2];
      end
      if (w_flag_we[0]) begin
        r_flags[1:0] <= commit_flags[1:0];
      end
      if (w_stall_inc && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
    end
  end

  assign ex_valid    = r_s[1].valid;
  assign ex_condex   = w_ex_condex;
  assign carry_in    = r_flags[3];
  assign wb_valid    = r_s[LAT].valid;
  assign wb_flag_we  = w_flag_we;
  assign flags       = r_flags;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_flag_hazard_controller.sv
// Directed bench for flag_hazard_controller (LAT=3, CNT_W=4); expected stage-1
// condition results are queued at issue and compared when ex_valid shows the entry.
module tb_flag_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [3:0] issue_cond;
  logic [1:0] issue_flagwrite;
  logic       issue_ready;
  logic       flush;
  logic       ex_valid;
  logic       ex_condex;
  logic       carry_in;
  logic [3:0] commit_flags;
  logic       wb_valid;
  logic [1:0] wb_flag_we;
  logic [3:0] flags;
  logic [3:0] stall_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt;
  logic [0:0] exp_q[$];

  logic [3:0] tbl_cond [12];
  logic       tbl_exp  [12];

  flag_hazard_controller #(.LAT(3), .CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_cond      (issue_cond),
    .issue_flagwrite (issue_flagwrite),
    .issue_ready     (issue_ready),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_condex       (ex_condex),
    .carry_in        (carry_in),
    .commit_flags    (commit_flags),
    .wb_valid        (wb_valid),
    .wb_flag_we      (wb_flag_we),
    .flags           (flags),
    .stall_count     (stall_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver: inputs change on the falling edge, combinational outputs settle by +1
  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic fl);
    issue_valid     = v;
    issue_cond      = c;
    issue_flagwrite = fw;
    flush           = fl;
    #1;
  endtask

  // Advance one cycle; scoreboard pops the expected cond result for each stage-1 entry
  task automatic tick();
    logic [0:0] e;
    @(posedge clk);
    @(negedge clk);
    if (ex_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected got ex_valid=1 exp=no queued entry");
      end else begin
        e = exp_q.pop_front();
        chk("sb_ex_condex", ex_condex, e);
      end
    end
  endtask

  initial begin
    tbl_cond = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    // Flags are {C,V,N,Z} = 1001 when this table runs
    tbl_exp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    issue_valid = 1'b0;
    issue_cond = 4'd0;
    issue_flagwrite = 2'b00;
    flush = 1'b0;
    commit_flags = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", issue_ready, 1);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_condex", ex_condex, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_we", wb_flag_we, 0);
    chk("rst_flags", flags, 0);
    chk("rst_carry", carry_in, 0);
    chk("rst_cnt", stall_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // T2: NZ writer then Z reader back to back
    drive(1, 4'd14, 2'b01, 0);
    chk("t2_w_ready", issue_ready, 1);
    exp_q.push_back(1'b1);
    tick();
    chk("t2_w_ex_valid", ex_valid, 1);
    drive(1, 4'd0, 2'b00, 0);
    chk("t2_stall1", issue_ready, 0);
    tick();
    chk("t2_bubble", ex_valid, 0);
    chk("t2_stall2", issue_ready, 0);
    commit_flags = 4'b0001;
    tick();
    chk("t2_accept", issue_ready, 1);
    chk("t2_wb_valid", wb_valid, 1);
    chk("t2_wb_we", wb_flag_we, 2'b01);
    chk("t2_cnt", stall_count, 2);
    exp_q.push_back(1'b1);
    tick();
    chk("t2_flags", flags, 4'b0001);
    chk("t2_r_ex_valid", ex_valid, 1);
    drive(0, 4'd0, 2'b00, 0);
    repeat (3) tick();
    chk("idle_condex", ex_condex, 0);

    // T3: CV writer in flight; NZ reader proceeds, CV+NZ reader stalls
    drive(1, 4'd14, 2'b10, 0);
    exp_q.push_back(1'b1);
    tick();
    drive(1, 4'd0, 2'b00, 0);
    chk("t3_disjoint_ready", issue_ready, 1);
    exp_q.push_back(1'b1);
    tick();
    drive(1, 4'd8, 2'b00, 0);
    chk("t3_stall", issue_ready, 0);
    tick();
    chk("t3_ready", issue_ready, 1);
    commit_flags = 4'b1000;
    exp_q.push_back(1'b0);
    tick();
    chk("t3_flags", flags, 4'b1001);
    chk("t3_carry", carry_in, 1);
    chk("t3_cnt", stall_count, 3);
    drive(0, 4'd0, 2'b00, 0);
    repeat (3) tick();

    // Cond table sweep with no writers in flight
    for (int k = 0; k < 12; k++) begin
      drive(1, tbl_cond[k], 2'b00, 0);
      chk("tbl_ready", issue_ready, 1);
      exp_q.push_back(tbl_exp[k]);
      tick();
    end
    drive(0, 4'd0, 2'b00, 0);
    repeat (3) tick();

    // T4: writer whose condition fails must not write
    drive(1, 4'd15, 2'b11, 0);
    exp_q.push_back(1'b0);
    tick();
    drive(0, 4'd0, 2'b00, 0);
    tick();
    tick();
    chk("t4_wb_valid", wb_valid, 1);
    chk("t4_wb_we", wb_flag_we, 2'b00);
    commit_flags = 4'b0110;
    tick();
    chk("t4_flags", flags, 4'b1001);

    // T5: flush while a writer sits in s[3]
    drive(1, 4'd14, 2'b11, 0);
    exp_q.push_back(1'b1);
    tick();
    drive(1, 4'd14, 2'b00, 0);
    chk("t5_x_ready", issue_ready, 1);
    exp_q.push_back(1'b1);
    tick();
    drive(1, 4'd0, 2'b00, 0);
    chk("t5_stall", issue_ready, 0);
    tick();
    drive(1, 4'd0, 2'b00, 1);
    chk("t5_ready_in_flush", issue_ready, 1);
    chk("t5_wb_valid_pre", wb_valid, 1);
    tick();
    chk("t5_flags", flags, 4'b1001);
    chk("t5_ex_valid", ex_valid, 0);
    chk("t5_wb_valid", wb_valid, 0);
    chk("t5_cnt", stall_count, 4);
    drive(1, 4'd0, 2'b00, 0);
    chk("t5_accept", issue_ready, 1);
    exp_q.push_back(1'b1);
    tick();
    chk("t5_r_ex_valid", ex_valid, 1);
    drive(0, 4'd0, 2'b00, 0);
    repeat (3) tick();

    // T6: repeated 2-cycle stalls drive the 4-bit counter into saturation
    commit_flags = 4'b0001;
    exp_cnt = 4;
    for (int it = 0; it < 7; it++) begin
      drive(1, 4'd14, 2'b01, 0);
      chk("t6_w_ready", issue_ready, 1);
      exp_q.push_back(1'b1);
      tick();
      drive(1, 4'd0, 2'b00, 0);
      chk("t6_stall_a", issue_ready, 0);
      tick();
      chk("t6_stall_b", issue_ready, 0);
      tick();
      chk("t6_accept", issue_ready, 1);
      exp_q.push_back(1'b1);
      tick();
      exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
      chk("t6_cnt", stall_count, exp_cnt);
    end
    drive(0, 4'd0, 2'b00, 0);
    repeat (3) tick();
    chk("t6_flags", flags, 4'b1001);

    // T1: asynchronous reset with writers in flight and a reader stalled
    drive(1, 4'd14, 2'b11, 0);
    exp_q.push_back(1'b1);
    tick();
    drive(1, 4'd14, 2'b11, 0);
    chk("t1_w2_ready", issue_ready, 1);
    exp_q.push_back(1'b1);
    tick();
    drive(1, 4'd0, 2'b00, 0);
    chk("t1_stall", issue_ready, 0);
    tick();
    chk("t1_stall_hold", issue_ready, 0);
    chk("t1_wb_valid_pre", wb_valid, 1);
    chk("t1_cnt_sat", stall_count, 15);
    commit_flags = 4'b1111;
    reset = 1'b1;
    #1;
    chk("t1_flags", flags, 0);
    chk("t1_carry", carry_in, 0);
    chk("t1_ex_valid", ex_valid, 0);
    chk("t1_wb_valid", wb_valid, 0);
    chk("t1_ready", issue_ready, 1);
    chk("t1_cnt", stall_count, 0);
    tick();
    chk("t1_flags_held", flags, 0);
    chk("t1_wb_valid_held", wb_valid, 0);
    reset = 1'b0;
    drive(0, 4'd0, 2'b00, 0);
    tick();
    chk("t1_post_ex_valid", ex_valid, 0);
    chk("t1_post_flags", flags, 0);
    chk("t1_post_cnt", stall_count, 0);

    chk("sb_drained", exp_q.size(), 0);

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
